// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that time-shares one combinational adder between
// NUM_REQ requesters. One operation is in flight at a time: a requester is
// granted in IDLE, its operands drive the adder during CALC, and the tagged
// sum is held in RESP until the consumer takes it.
module adder_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   input  logic [WIDTH:0]           add_sum,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH:0]           rsp_sum,
   output logic [ID_W-1:0]          rsp_id
);

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t              state_reg, state_next;
   logic [ID_W-1:0]     rr_ptr_reg;
   logic [ID_W-1:0]     grant_id_reg;
   logic [WIDTH-1:0]    add_a_reg, add_b_reg;
   logic                rsp_valid_reg;
   logic [WIDTH:0]      rsp_sum_reg;
   logic [ID_W-1:0]     rsp_id_reg;

   logic [WIDTH-1:0]    op_a [NUM_REQ];
   logic [WIDTH-1:0]    op_b [NUM_REQ];
   logic [ID_W-1:0]     cand_id [NUM_REQ];
   logic                gnt_found;
   logic [ID_W-1:0]     gnt_id;

   // Unpack operands and build the scan order starting at the pointer.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign op_a[gi]    = req_a[gi*WIDTH +: WIDTH];
         assign op_b[gi]    = req_b[gi*WIDTH +: WIDTH];
         assign cand_id[gi] = ID_W'((int'(rr_ptr_reg) + gi) % NUM_REQ);
      end
   endgenerate

   // Arbiter: the first valid candidate in scan order wins (walk backwards
   // so the lowest offset overrides).
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[cand_id[k]]) begin
            gnt_found = 1'b1;
            gnt_id    = cand_id[k];
         end
      end
   end

   // Next-state and accept strobe; no accept is offered while in reset.
   always_comb begin
      state_next = state_reg;
      req_ready  = '0;
      unique case (state_reg)
         IDLE: begin
            if (gnt_found && !rst) begin
               req_ready[gnt_id] = 1'b1;
               state_next        = CALC;
            end
         end
         CALC: state_next = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, operand, response and pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         grant_id_reg  <= '0;
         add_a_reg     <= '0;
         add_b_reg     <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_sum_reg   <= '0;
         rsp_id_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && gnt_found) begin
            add_a_reg    <= op_a[gnt_id];
            add_b_reg    <= op_b[gnt_id];
            grant_id_reg <= gnt_id;
         end
         if (state_reg == CALC) begin
            rsp_sum_reg   <= add_sum;
            rsp_id_reg    <= grant_id_reg;
            rsp_valid_reg <= 1'b1;
         end
         if (state_reg == RESP && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rr_ptr_reg    <= (grant_id_reg == ID_W'(NUM_REQ - 1)) ? '0
                                                                  : grant_id_reg + ID_W'(1);
         end
      end
   end

   assign add_a     = add_a_reg;
   assign add_b     = add_b_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_sum   = rsp_sum_reg;
   assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Testbench for adder_rr_scheduler: table of single transactions plus
// hand-written sequences for fairness, back-pressure and mid-operation reset.
module tb_adder_rr_scheduler;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int ID_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
   logic [WIDTH-1:0]         add_a, add_b;
   logic [WIDTH:0]           add_sum;
   logic                     rsp_valid, rsp_ready;
   logic [WIDTH:0]           rsp_sum;
   logic [ID_W-1:0]          rsp_id;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] a;
      logic [31:0] b;
      int          gnt;
      logic [8:0]  sum;
   } vec_t;

   localparam logic [31:0] STD_A = 32'h40302010;
   localparam logic [31:0] STD_B = 32'h04030201;

   vec_t vecs [13];

   adder_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_id(rsp_id)
   );

   // The shared adder
   assign add_sum = {1'b0, add_a} + {1'b0, add_b};

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int n, input vec_t v);
      logic [31:0] a, b;
      a = v.a;
      b = v.b;
      req_valid = v.valid;
      req_a     = a;
      req_b     = b;
      rsp_ready = 1'b1;
      #1;
      chk("grant", 64'(req_ready), 64'(4'b0001 << v.gnt));
      step();
      req_valid = '0;
      #1;
      chk("calc_ready", 64'(req_ready), 64'd0);
      chk("add_a", 64'(add_a), 64'(a[v.gnt*8 +: 8]));
      step();
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_sum", 64'(rsp_sum), 64'(v.sum));
      chk("rsp_id", 64'(rsp_id), 64'(v.gnt));
      $display("vec %0d: valid=%b grant=%0d sum=%0h id=%0d", n, v.valid, v.gnt, rsp_sum, rsp_id);
      step();
      chk("rsp_drop", 64'(rsp_valid), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // Each entry's grant follows from the pointer left by the previous one.
      vecs[0]  = '{4'b0001, 32'h00000003, 32'h00000005, 0, 9'd8};
      vecs[1]  = '{4'b0100, 32'h00FF0000, 32'h00010000, 2, 9'h100};
      vecs[2]  = '{4'b1111, STD_A, STD_B, 3, 9'h044};
      vecs[3]  = '{4'b1111, STD_A, STD_B, 0, 9'h011};
      vecs[4]  = '{4'b1111, STD_A, STD_B, 1, 9'h022};
      vecs[5]  = '{4'b1111, STD_A, STD_B, 2, 9'h033};
      vecs[6]  = '{4'b1111, STD_A, STD_B, 3, 9'h044};
      vecs[7]  = '{4'b0010, 32'h0000C800, 32'h00006400, 1, 9'h12C};
      vecs[8]  = '{4'b1000, 32'h80000000, 32'h80000000, 3, 9'h100};
      vecs[9]  = '{4'b0100, STD_A, STD_B, 2, 9'h033};
      vecs[10] = '{4'b1001, STD_A, STD_B, 3, 9'h044};
      vecs[11] = '{4'b1001, STD_A, STD_B, 0, 9'h011};
      vecs[12] = '{4'b0001, 32'h00000000, 32'h00000000, 0, 9'h000};

      req_a = '0;
      req_b = '0;
      do_reset();
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_sum", 64'(rsp_sum), 64'd0);
      chk("rst_id", 64'(rsp_id), 64'd0);
      chk("rst_add_a", 64'(add_a), 64'd0);
      chk("rst_add_b", 64'(add_b), 64'd0);

      for (int i = 0; i < 13; i++) begin
         run_vec(i, vecs[i]);
      end

      // Fairness: all requesters valid continuously, consumer always ready.
      do_reset();
      req_valid = 4'b1111;
      req_a = STD_A;
      req_b = STD_B;
      rsp_ready = 1'b1;
      #1;
      for (int c = 0; c < 18; c++) begin
         chk("rr_ready", 64'(req_ready), (c % 3 == 0) ? 64'(4'b0001 << ((c / 3) % 4)) : 64'd0);
         chk("rr_rsp_valid", 64'(rsp_valid), (c % 3 == 2) ? 64'd1 : 64'd0);
         if (c % 3 == 2) begin
            chk("rr_rsp_id", 64'(rsp_id), 64'((c / 3) % 4));
            $display("rr cycle %0d: response id=%0d sum=%0h", c, rsp_id, rsp_sum);
         end
         step();
      end

      // Back-pressure: requester 1 granted, response held for 5 cycles.
      do_reset();
      req_a = 32'h00000705;
      req_b = 32'h00000906;
      req_valid = 4'b0010;
      #1;
      chk("bp_grant", 64'(req_ready), 64'(4'b0010));
      step();
      req_valid = 4'b0001;
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_sum", 64'(rsp_sum), 64'd16);
         chk("bp_id", 64'(rsp_id), 64'd1);
         chk("bp_ready", 64'(req_ready), 64'd0);
         step();
      end
      $display("bp: held id=%0d sum=%0h for 5 cycles", rsp_id, rsp_sum);
      rsp_ready = 1'b1;
      #1;
      chk("bp_valid_last", 64'(rsp_valid), 64'd1);
      step();
      chk("bp_next_grant", 64'(req_ready), 64'(4'b0001));
      step();
      req_valid = '0;
      step();
      chk("bp_next_sum", 64'(rsp_sum), 64'd11);
      chk("bp_next_id", 64'(rsp_id), 64'd0);
      $display("bp: next response id=%0d sum=%0h", rsp_id, rsp_sum);
      step();

      // Reset in RESP: pointer must return to 0 even though it had moved.
      do_reset();
      run_vec(100, vecs[0]);
      req_a = 32'h00001100;
      req_b = 32'h00002200;
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1;
      chk("rr_pre_grant", 64'(req_ready), 64'(4'b0010));
      step();
      req_valid = '0;
      step();
      chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_sum", 64'(rsp_sum), 64'd0);
      chk("mid_rst_add_a", 64'(add_a), 64'd0);
      req_valid = 4'b0011;
      #1;
      chk("mid_rst_grant", 64'(req_ready), 64'(4'b0001));
      $display("reset in RESP: post-reset grant=%b", req_ready);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one combinational Adder between NUM_REQ independent requesters.
- Round-robin arbiter, operand registers and response sequencer sit between the requester ports and the Adder a/b/sum pins.
- Instantiated in top alongside the Adder; the test drives the requester side through tb_interface.
- One operation in flight at a time; each result is returned tagged with the requester id.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits.
- ID_W, $clog2(NUM_REQ), requester id width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot accept strobe.
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed operand B, same packing.
- add_a  output  WIDTH  registered operand A to the Adder.
- add_b  output  WIDTH  registered operand B to the Adder.
- add_sum  input  WIDTH+1  combinational sum from the Adder, including carry.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_sum  output  WIDTH+1  registered result.
- rsp_id  output  ID_W  id of the requester that owns rsp_sum.

Behaviour:
- Reset values: state=IDLE; req_ready=0; add_a=0; add_b=0; rsp_valid=0; rsp_sum=0; rsp_id=0; rr_ptr=0 (requester 0 has highest priority).
- FSM has three states: IDLE, CALC, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - If any request is present: req_ready[g]=1 for exactly this cycle (combinational from state and req_valid); latch add_a/add_b from slice g; latch grant id; go to CALC.
  - If no request is present: stay in IDLE, req_ready=0.
- CALC (one cycle):
  - rsp_sum <= add_sum; rsp_id <= grant id; rsp_valid <= 1; go to RESP.
  - The Adder is combinational, so add_sum reflects add_a/add_b within this cycle.
- RESP:
  - Hold rsp_valid, rsp_sum and rsp_id stable until rsp_ready=1.
  - On the rsp_ready cycle: rsp_valid <= 0; rr_ptr <= (grant id + 1) mod NUM_REQ; go to IDLE.
- Throughput and latency:
  - Minimum 3 cycles per operation.
  - rsp_valid rises 2 clocks after the req_ready cycle.
- req_ready is 0 in CALC and RESP. Requests stay pending; requesters must hold valid and operands until accepted.
- Handshake: a transfer occurs only when req_valid[i] & req_ready[i]. Deasserting req_valid before acceptance is legal and drops the request.
- Arithmetic:
  - Unsigned, full WIDTH+1 result; no truncation.
  - Example: 8'hFF + 8'h01 = 9'h100.
- Pointer wrap: a grant to requester NUM_REQ-1 sets rr_ptr=0.
- Simultaneous requests: exactly one grant per IDLE cycle. No requester waits more than NUM_REQ-1 other grants.
- rsp_ready held high: RESP lasts one cycle, giving back-to-back 3-cycle operations.
- Reset mid-operation (CALC or RESP): the in-flight result is discarded; all registers return to reset values on the next edge.

Test Plan:
- Single request: req_valid=4'b0001, a0=8'd3, b0=8'd5, rsp_ready=1 -> req_ready=4'b0001 for one cycle; 2 cycles later rsp_valid=1, rsp_sum=9'd8, rsp_id=0.
- Carry: requester 2 sends a=8'hFF, b=8'h01 -> rsp_sum=9'h100, rsp_id=2.
- Round-robin fairness: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 with one response every 3 cycles.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_sum and rsp_id stable, req_ready=0 throughout; next grant occurs only after rsp_ready=1.
- Wrap and skip: last grant 3; then req_valid=4'b0100 -> grant 2; next with req_valid=4'b1001 -> grant 3, then 0.
- Reset in RESP: assert rst while rsp_valid=1 -> next cycle rsp_valid=0, state=IDLE, rr_ptr=0; a pending request from requester 1 with requester 0 also valid is granted to 0.
